// File: rtl/seq_shift_add_mult_24_pkg.sv
// Shared definitions for the iterative shift-add multiplier.
package seq_shift_add_mult_24_pkg;

  localparam int unsigned DEF_WIDTH = 24;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    SIGN = 2'd2,
    DONE = 2'd3
  } state_t;

  // Iteration counter width; never narrower than one bit.
  function automatic int unsigned count_bits(input int unsigned w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/seq_shift_add_mult_24_if.sv
// Operand/result valid-ready bus of the shift-add multiplier.
interface seq_shift_add_mult_24_if
  import seq_shift_add_mult_24_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
);

  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic               is_signed;
  logic               out_valid;
  logic               out_ready;
  logic [2*WIDTH-1:0] p;
  logic               signed_out;

  modport master (
    output in_valid, a, b, is_signed, out_ready,
    input  in_ready, out_valid, p, signed_out
  );

  modport slave (
    input  in_valid, a, b, is_signed, out_ready,
    output in_ready, out_valid, p, signed_out
  );

endinterface

// File: rtl/seq_shift_add_mult_24_twos_negate.sv
// Conditional two's-complement negation, purely combinational.
module twos_negate #(
  parameter int unsigned W = 24
) (
  input  logic         en,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);

  // Negate when enabled, pass through otherwise; -0 naturally wraps to 0.
  always_comb begin
    dout = en ? (~din + W'(1)) : din;
  end

endmodule

// File: rtl/seq_shift_add_mult_24.sv
// Iterative shift-add multiplier, signed/unsigned selectable, valid/ready on both sides.
module seq_shift_add_mult_24
  import seq_shift_add_mult_24_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
) (
  input logic                    clk,
  input logic                    rst,
  seq_shift_add_mult_24_if.slave bus
);

  localparam int unsigned PW = 2 * WIDTH;
  localparam int unsigned CW = count_bits(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t          state;
  logic [CW-1:0]   count;
  logic [PW-1:0]   acc;
  logic [WIDTH-1:0] mag_a;
  logic [WIDTH-1:0] mag_b;
  logic            neg;
  logic [WIDTH-1:0] abs_a;
  logic [WIDTH-1:0] abs_b;
  logic [PW-1:0]   fixed;
  logic [PW-1:0]   addend;

  logic            in_ready_q;
  logic            out_valid_q;
  logic [PW-1:0]   p_q;
  logic            signed_out_q;

  twos_negate #(.W(WIDTH)) u_abs_a (
    .en   (bus.is_signed & bus.a[WIDTH-1]),
    .din  (bus.a),
    .dout (abs_a)
  );

  twos_negate #(.W(WIDTH)) u_abs_b (
    .en   (bus.is_signed & bus.b[WIDTH-1]),
    .din  (bus.b),
    .dout (abs_b)
  );

  twos_negate #(.W(PW)) u_sign_fix (
    .en   (neg),
    .din  (acc),
    .dout (fixed)
  );

  // Partial product for the current multiplier bit.
  always_comb begin
    addend = '0;
    if (mag_b[count]) begin
      addend = {{WIDTH{1'b0}}, mag_a} << count;
    end
  end

  // Control FSM, datapath and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      count        <= '0;
      acc          <= '0;
      mag_a        <= '0;
      mag_b        <= '0;
      neg          <= 1'b0;
      in_ready_q   <= 1'b1;
      out_valid_q  <= 1'b0;
      p_q          <= '0;
      signed_out_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid && in_ready_q) begin
            mag_a        <= abs_a;
            mag_b        <= abs_b;
            neg          <= bus.is_signed & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
            signed_out_q <= bus.is_signed;
            acc          <= '0;
            count        <= '0;
            in_ready_q   <= 1'b0;
            state        <= RUN;
          end
        end
        RUN: begin
          acc <= acc + addend;
          if (count == LAST) begin
            state <= SIGN;
          end else begin
            count <= count + 1'b1;
          end
        end
        SIGN: begin
          p_q         <= fixed;
          out_valid_q <= 1'b1;
          state       <= DONE;
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready   = in_ready_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.p          = p_q;
  assign bus.signed_out = signed_out_q;

endmodule

// File: tb/tb_seq_shift_add_mult_24.sv
// Self-checking bench for seq_shift_add_mult_24: vector table, corner sequences, random soak.
module tb_seq_shift_add_mult_24;

  localparam int unsigned W = 24;
  localparam int LATENCY = W + 1;

  logic clk;
  logic rst;
  int   tests;
  int   failed;

  seq_shift_add_mult_24_if #(.WIDTH(W)) bus ();

  seq_shift_add_mult_24 #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic          s;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic [2*W-1:0] p;
  } vec_t;

  task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      failed++;
      $display("FAIL %s: got %h, expected %h", nm, got, exp);
    end
  endtask

  // Reference: true mathematical product truncated to 2*W bits.
  function automatic logic [2*W-1:0] ref_mul(input logic s, input logic [W-1:0] a,
                                              input logic [W-1:0] b);
    longint x;
    longint y;
    longint r;
    if (s) begin
      x = longint'($signed(a));
      y = longint'($signed(b));
    end else begin
      x = longint'({40'd0, a});
      y = longint'({40'd0, b});
    end
    r = x * y;
    return r[2*W-1:0];
  endfunction

  // One full transaction. hold = extra backpressure cycles in DONE; junk = pulse
  // in_valid with new data while busy; early = out_ready high from the accept edge.
  task automatic run_op(input string nm, input logic s, input logic [W-1:0] av,
                        input logic [W-1:0] bv, input int hold, input bit junk,
                        input bit early, input logic [2*W-1:0] exp_p);
    int lat;
    int guard;
    logic [2*W-1:0] held;
    @(negedge clk);
    guard = 0;
    while (!bus.in_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 200) check({nm, " ready_timeout"}, 64'd0, 64'd1);
    bus.in_valid  = 1'b1;
    bus.a         = av;
    bus.b         = bv;
    bus.is_signed = s;
    @(posedge clk);
    #1;
    bus.in_valid  = 1'b0;
    bus.out_ready = early;
    if (junk) begin
      bus.in_valid = 1'b1;
      bus.a = W'($urandom);
      bus.b = W'($urandom);
      bus.is_signed = ~s;
    end
    lat = 0;
    while (!bus.out_valid && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check({nm, " latency"}, 64'(lat), 64'(LATENCY));
    check({nm, " p"}, 64'(bus.p), 64'(exp_p));
    check({nm, " signed_out"}, 64'(bus.signed_out), 64'(s));
    held = bus.p;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      check({nm, " bp_p"}, 64'(bus.p), 64'(held));
      check({nm, " bp_valid"}, 64'(bus.out_valid), 64'd1);
      check({nm, " bp_inready"}, 64'(bus.in_ready), 64'd0);
    end
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b0;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    check({nm, " release_valid"}, 64'(bus.out_valid), 64'd0);
    check({nm, " release_inready"}, 64'(bus.in_ready), 64'd1);
    check({nm, " p_held_idle"}, 64'(bus.p), 64'(held));
  endtask

  vec_t vecs[6];

  initial begin
    tests = 0;
    failed = 0;
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.is_signed = 1'b0;
    bus.out_ready = 1'b0;
    rst = 1'b1;
    #12;
    check("reset in_ready", 64'(bus.in_ready), 64'd1);
    check("reset out_valid", 64'(bus.out_valid), 64'd0);
    check("reset p", 64'(bus.p), 64'd0);
    check("reset signed_out", 64'(bus.signed_out), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    vecs[0] = '{1'b1, 24'hFFFFFF, 24'h000001, 48'hFFFF_FFFF_FFFF};
    vecs[1] = '{1'b0, 24'hFFFFFF, 24'h000001, 48'h0000_00FF_FFFF};
    vecs[2] = '{1'b1, 24'h800000, 24'h800000, 48'h4000_0000_0000};
    vecs[3] = '{1'b0, 24'hFFFFFF, 24'hFFFFFF, 48'hFFFF_FE00_0001};
    vecs[4] = '{1'b1, 24'h000000, 24'hFFFFFF, 48'h0000_0000_0000};
    vecs[5] = '{1'b1, 24'h000003, 24'hFFFFFB, 48'hFFFF_FFFF_FFF1};
    for (int i = 0; i < 6; i++) begin
      run_op($sformatf("vec%0d", i), vecs[i].s, vecs[i].a, vecs[i].b, 0, 1'b0, 1'b0, vecs[i].p);
    end

    // Backpressure with ignored in_valid pulses while busy.
    run_op("backpressure", 1'b1, 24'h123456, 24'hFEDCBA, 5, 1'b1, 1'b0,
           ref_mul(1'b1, 24'h123456, 24'hFEDCBA));
    // Nothing must have been captured: still idle one edge later.
    @(posedge clk);
    #1;
    check("no_capture inready", 64'(bus.in_ready), 64'd1);

    // Async reset in mid-RUN (count reaches 10), then a normal op.
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.a = 24'h00ABCD;
    bus.b = 24'h00F00F;
    bus.is_signed = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("midrun_rst in_ready", 64'(bus.in_ready), 64'd1);
    check("midrun_rst out_valid", 64'(bus.out_valid), 64'd0);
    check("midrun_rst p", 64'(bus.p), 64'd0);
    check("midrun_rst signed_out", 64'(bus.signed_out), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    run_op("after_rst", 1'b1, 24'h000003, 24'hFFFFFB, 0, 1'b0, 1'b0, 48'hFFFF_FFFF_FFF1);

    // Random soak, mixing signedness, extreme operands and out_ready patterns.
    for (int n = 0; n < 40; n++) begin
      logic          s;
      logic [W-1:0]  av;
      logic [W-1:0]  bv;
      bit            early;
      int            hold;
      s = 1'($urandom);
      av = W'($urandom);
      bv = W'($urandom);
      case ($urandom_range(0, 5))
        0: av = 24'h800000;
        1: bv = 24'hFFFFFF;
        2: av = '0;
        default: ;
      endcase
      early = 1'($urandom);
      hold = early ? 0 : int'($urandom_range(0, 3));
      run_op($sformatf("soak%0d", n), s, av, bv, hold, 1'($urandom), early, ref_mul(s, av, bv));
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
